// File: rtl/smem_store_unit_pkg.sv
// smem_store_unit_pkg
//   Shared constants, drain FSM encoding and packing helpers for the
//   shared-memory store unit (current-interval array + match-memory array).
package smem_store_unit_pkg;

  localparam int SMEM_DEPTH = 128;  // entries per array
  localparam int SMEM_AW    = 7;    // entry address width
  localparam int SMEM_CL    = 512;  // drain cache-line width
  localparam int SMEM_EW    = 256;  // entry width {info, x2, x1, x0}
  localparam int SMEM_CW    = 8;    // drain count width (0..128)

  typedef logic [SMEM_EW-1:0] entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } drain_st_e;

  // x0 lands in the low 64 bits
  function automatic entry_t pack_entry(input logic [63:0] info,
                                        input logic [63:0] x2,
                                        input logic [63:0] x1,
                                        input logic [63:0] x0);
    return {info, x2, x1, x0};
  endfunction

  // Two-entry window {hi, lo} -> line; hi is zeroed past the end of an odd drain
  function automatic logic [2*SMEM_EW-1:0] make_line(input logic [2*SMEM_EW-1:0] win,
                                                     input logic                 hi_ok);
    return {(hi_ok ? win[2*SMEM_EW-1:SMEM_EW] : {SMEM_EW{1'b0}}), win[SMEM_EW-1:0]};
  endfunction

endpackage

// File: rtl/smem_store_if.sv
// smem_store_if
//   Bundles the store unit's bus: two write ports (curr, mem), the curr read
//   port with stall, the drain control and the cache-line stream.
//   slave  : the store unit side
//   master : the producer / consumer side (pipeline, line sink)
interface smem_store_if
  import smem_store_unit_pkg::*;
#(
  parameter int CL = SMEM_CL
);
  logic               stall;
  logic               store_valid_curr;
  logic [63:0]        curr_x_0, curr_x_1, curr_x_2, curr_x_info;
  logic [SMEM_AW-1:0] curr_x_addr;
  logic               store_valid_mem;
  logic [63:0]        mem_x_0, mem_x_1, mem_x_2, mem_x_info;
  logic [SMEM_AW-1:0] mem_x_addr;
  logic               rd_en;
  logic [SMEM_AW-1:0] rd_addr;
  logic               rd_valid;
  logic [SMEM_EW-1:0] rd_data;
  logic               drain_start;
  logic [SMEM_CW-1:0] drain_cnt;
  logic               cl_valid;
  logic               cl_ready;
  logic [CL-1:0]      cl_data;
  logic               cl_last;
  logic               busy;
  logic               drain_done;

  modport slave (
    input  stall, store_valid_curr, curr_x_0, curr_x_1, curr_x_2, curr_x_info, curr_x_addr,
           store_valid_mem, mem_x_0, mem_x_1, mem_x_2, mem_x_info, mem_x_addr,
           rd_en, rd_addr, drain_start, drain_cnt, cl_ready,
    output rd_valid, rd_data, cl_valid, cl_data, cl_last, busy, drain_done
  );

  modport master (
    output stall, store_valid_curr, curr_x_0, curr_x_1, curr_x_2, curr_x_info, curr_x_addr,
           store_valid_mem, mem_x_0, mem_x_1, mem_x_2, mem_x_info, mem_x_addr,
           rd_en, rd_addr, drain_start, drain_cnt, cl_ready,
    input  rd_valid, rd_data, cl_valid, cl_data, cl_last, busy, drain_done
  );
endinterface

// File: rtl/smem_entry_ram.sv
// smem_entry_ram
//   DEPTH x EW array, one write port, one combinational read port.
//   The read port returns RD_N consecutive entries starting at raddr_i
//   (address wraps), so one lookup can feed a whole drain line.
//   A write to an address being read in the same cycle is forwarded.
//   clk     : clock
//   we_i    : write enable;  waddr_i / wdata_i : write address / data
//   raddr_i : read base address;  rdata_o : {entry[raddr+RD_N-1] .. entry[raddr]}
module smem_entry_ram
  import smem_store_unit_pkg::*;
#(
  parameter int DEPTH = SMEM_DEPTH,
  parameter int EW    = SMEM_EW,
  parameter int RD_N  = 1,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [EW-1:0]      wdata_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [RD_N*EW-1:0] rdata_o
);

  // Contents are intentionally not reset.
  logic [EW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  for (genvar k = 0; k < RD_N; k++) begin : g_rd
    logic [AW-1:0] addr;
    assign addr = raddr_i + AW'(k);
    assign rdata_o[k*EW +: EW] = (we_i && (waddr_i == addr)) ? wdata_i : mem_q[addr];
  end

endmodule

// File: rtl/smem_store_unit.sv
// smem_store_unit
//   Two entry arrays: curr (written by the current interval, read back with
//   latency 1 under pipeline stall) and mem (match memory, drained as a
//   stream of CL-bit lines, two entries per line).
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (arrays keep their contents)
//   bus  : smem_store_if.slave -- write ports, read port, drain control/stream
module smem_store_unit
  import smem_store_unit_pkg::*;
#(
  parameter int DEPTH = SMEM_DEPTH,
  parameter int CL    = SMEM_CL
) (
  input  logic          clk,
  input  logic          rst,
  smem_store_if.slave   bus
);

  entry_t               curr_wdata, mem_wdata, curr_rdata;
  logic [2*SMEM_EW-1:0] mem_win;
  logic [SMEM_AW-1:0]   mem_raddr;

  assign curr_wdata = pack_entry(bus.curr_x_info, bus.curr_x_2, bus.curr_x_1, bus.curr_x_0);
  assign mem_wdata  = pack_entry(bus.mem_x_info,  bus.mem_x_2,  bus.mem_x_1,  bus.mem_x_0);

  smem_entry_ram #(.DEPTH(DEPTH), .EW(SMEM_EW), .RD_N(1), .AW(SMEM_AW)) u_curr (
    .clk     (clk),
    .we_i    (bus.store_valid_curr),
    .waddr_i (bus.curr_x_addr),
    .wdata_i (curr_wdata),
    .raddr_i (bus.rd_addr),
    .rdata_o (curr_rdata)
  );

  // mem reads a two-entry window: exactly one drain line per lookup
  smem_entry_ram #(.DEPTH(DEPTH), .EW(SMEM_EW), .RD_N(2), .AW(SMEM_AW)) u_mem (
    .clk     (clk),
    .we_i    (bus.store_valid_mem),
    .waddr_i (bus.mem_x_addr),
    .wdata_i (mem_wdata),
    .raddr_i (mem_raddr),
    .rdata_o (mem_win)
  );

  // ---------------- curr read port ----------------
  logic         rd_valid_q;
  entry_t       rd_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else if (!bus.stall) begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) rd_data_q <= curr_rdata;
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;

  // ---------------- drain FSM ----------------
  drain_st_e          state_q, state_d;
  logic [SMEM_CW-1:0] idx_q, idx_d, cnt_q, cnt_d, idx_nxt;
  logic               cl_valid_q, cl_valid_d, cl_last_q, cl_last_d;
  logic [CL-1:0]      cl_data_q, cl_data_d;

  // Lines are loaded into the output register on the edge before they are
  // presented, so the window looks at the line that comes next: entry 0 while
  // idle (drain start), idx+2 while draining (accept of the current line).
  assign idx_nxt   = idx_q + SMEM_CW'(2);
  assign mem_raddr = (state_q == ST_IDLE) ? '0 : idx_nxt[SMEM_AW-1:0];

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    cl_valid_d = cl_valid_q;
    cl_data_d  = cl_data_q;
    cl_last_d  = cl_last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.drain_start) begin
          cnt_d = bus.drain_cnt;
          idx_d = '0;
          if (bus.drain_cnt == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d    = ST_DRAIN;
            cl_valid_d = 1'b1;
            cl_data_d  = CL'(make_line(mem_win, bus.drain_cnt > SMEM_CW'(1)));
            cl_last_d  = bus.drain_cnt <= SMEM_CW'(2);
          end
        end
      end
      ST_DRAIN: begin
        if (cl_valid_q && bus.cl_ready) begin
          if (cl_last_q) begin
            state_d    = ST_DONE;
            cl_valid_d = 1'b0;
            cl_last_d  = 1'b0;
          end else begin
            idx_d     = idx_nxt;
            cl_data_d = CL'(make_line(mem_win, (idx_nxt + SMEM_CW'(1)) < cnt_q));
            cl_last_d = (idx_nxt + SMEM_CW'(2)) >= cnt_q;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      cl_valid_q <= 1'b0;
      cl_data_q  <= '0;
      cl_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      cl_valid_q <= cl_valid_d;
      cl_data_q  <= cl_data_d;
      cl_last_q  <= cl_last_d;
    end
  end

  assign bus.cl_valid   = cl_valid_q;
  assign bus.cl_data    = cl_data_q;
  assign bus.cl_last    = cl_last_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.drain_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_smem_store_unit.sv
// tb_smem_store_unit
//   Directed bench: read port (latency, bypass, stall hold) and the mem drain
//   stream (odd/even counts, backpressure, zero count, reset mid-drain).
//   Expected read data and drain lines come from a reference copy of both
//   arrays and are queued when the stimulus is driven.
module tb_smem_store_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  smem_store_if #(.CL(512)) bus ();

  smem_store_unit #(.DEPTH(128), .CL(512)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [511:0] data;
    logic         last;
  } line_t;

  logic [255:0] curr_m [128];
  logic [255:0] mem_m  [128];
  logic [255:0] sb_rd [$];
  line_t        sb_line [$];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic set_curr(input logic [6:0] a, input logic [255:0] d);
    bus.store_valid_curr = 1'b1;
    bus.curr_x_addr      = a;
    {bus.curr_x_info, bus.curr_x_2, bus.curr_x_1, bus.curr_x_0} = d;
    curr_m[a] = d;
  endtask

  task automatic set_mem(input logic [6:0] a, input logic [255:0] d);
    bus.store_valid_mem = 1'b1;
    bus.mem_x_addr      = a;
    {bus.mem_x_info, bus.mem_x_2, bus.mem_x_1, bus.mem_x_0} = d;
    mem_m[a] = d;
  endtask

  task automatic fill_mem(input int n);
    for (int i = 0; i < n; i++) begin
      set_mem(7'(i), rnd256());
      cyc();
    end
    bus.store_valid_mem = 1'b0;
  endtask

  task automatic push_lines(input int cnt);
    line_t l;
    for (int i = 0; i < cnt; i += 2) begin
      l.data = {((i + 1 < cnt) ? mem_m[i+1] : 256'h0), mem_m[i]};
      l.last = (i + 2 >= cnt);
      sb_line.push_back(l);
    end
  endtask

  // Consume the queued lines; toggle=1 alternates cl_ready and fires a
  // spurious drain_start mid-drain.
  task automatic drain_loop(input bit toggle, input int exp_lines);
    int           lines = 0;
    bit           done = 0;
    bit           have_held = 0;
    logic [511:0] held = '0;
    line_t        e;
    for (int c = 0; c < 200 && !done; c++) begin
      bus.cl_ready    = toggle ? c[0] : 1'b1;
      bus.drain_start = toggle && (c == 3);
      bus.drain_cnt   = 8'd2;
      if (bus.cl_valid) begin
        if (have_held) chk("cl_data_stable", bus.cl_data, held);
        if (bus.cl_ready) begin
          e = sb_line.pop_front();
          chk("cl_data", bus.cl_data, e.data);
          chk("cl_last", 512'(bus.cl_last), 512'(e.last));
          lines++;
          have_held = 0;
          if (e.last) done = 1;
        end else begin
          held      = bus.cl_data;
          have_held = 1;
        end
      end
      cyc();
    end
    bus.drain_start = 1'b0;
    if (!done) begin
      n_chk++;
      n_err++;
      $error("FAIL drain_timeout: observed %0d lines expected %0d", lines, exp_lines);
    end
    chk("drain_lines", 512'(lines), 512'(exp_lines));
    chk("post_last_valid", 512'(bus.cl_valid), 512'(0));
    chk("drain_done_pulse", 512'(bus.drain_done), 512'(1));
    bus.cl_ready = 1'b0;
    cyc();
    chk("drain_done_clear", 512'(bus.drain_done), 512'(0));
    chk("busy_clear", 512'(bus.busy), 512'(0));
  endtask

  logic [255:0] a_val, b_val;

  initial begin
    rst = 1'b1;
    bus.stall = 0; bus.store_valid_curr = 0; bus.store_valid_mem = 0;
    bus.curr_x_0 = 0; bus.curr_x_1 = 0; bus.curr_x_2 = 0; bus.curr_x_info = 0; bus.curr_x_addr = 0;
    bus.mem_x_0 = 0; bus.mem_x_1 = 0; bus.mem_x_2 = 0; bus.mem_x_info = 0; bus.mem_x_addr = 0;
    bus.rd_en = 0; bus.rd_addr = 0; bus.drain_start = 0; bus.drain_cnt = 0; bus.cl_ready = 0;
    cyc(); cyc();

    // reset state
    chk("rst_rd_valid", 512'(bus.rd_valid), 512'(0));
    chk("rst_rd_data", 512'(bus.rd_data), 512'(0));
    chk("rst_cl_valid", 512'(bus.cl_valid), 512'(0));
    chk("rst_cl_data", bus.cl_data, 512'(0));
    chk("rst_cl_last", 512'(bus.cl_last), 512'(0));
    chk("rst_busy", 512'(bus.busy), 512'(0));
    chk("rst_drain_done", 512'(bus.drain_done), 512'(0));
    rst = 1'b0;

    // write curr[5] = {4,3,2,1}, read back with latency 1
    set_curr(7'd5, {64'd4, 64'd3, 64'd2, 64'd1});
    cyc();
    bus.store_valid_curr = 0;
    bus.rd_en = 1; bus.rd_addr = 7'd5;
    sb_rd.push_back(curr_m[5]);
    cyc();
    bus.rd_en = 0;
    chk("rd_valid", 512'(bus.rd_valid), 512'(1));
    chk("rd_data_5", 512'(bus.rd_data), 512'(sb_rd.pop_front()));
    cyc();
    chk("rd_valid_drop", 512'(bus.rd_valid), 512'(0));
    chk("rd_data_hold", 512'(bus.rd_data), 512'(curr_m[5]));

    // same-cycle write and read of curr[9] returns the new data
    a_val = rnd256();
    set_curr(7'd9, a_val);
    bus.rd_en = 1; bus.rd_addr = 7'd9;
    sb_rd.push_back(a_val);
    cyc();
    chk("bypass_valid", 512'(bus.rd_valid), 512'(1));
    chk("bypass_data", 512'(bus.rd_data), 512'(sb_rd.pop_front()));

    // stall for 3 cycles with rd_en asserted; a write lands meanwhile
    b_val = rnd256();
    set_curr(7'd9, b_val);
    bus.stall = 1; bus.rd_en = 1; bus.rd_addr = 7'd5;
    for (int i = 0; i < 3; i++) begin
      cyc();
      bus.store_valid_curr = 0;
      chk("stall_valid", 512'(bus.rd_valid), 512'(1));
      chk("stall_data", 512'(bus.rd_data), 512'(a_val));
    end
    bus.stall = 0; bus.rd_addr = 7'd9;
    sb_rd.push_back(curr_m[9]);
    cyc();
    bus.rd_en = 0;
    chk("write_in_stall", 512'(bus.rd_data), 512'(sb_rd.pop_front()));

    // odd drain of 5 entries, cl_ready held high; mem[5] filled so the
    // zeroed upper half of the last line is visible
    fill_mem(6);
    push_lines(5);
    bus.drain_cnt = 8'd5; bus.drain_start = 1; bus.cl_ready = 1;
    cyc();
    bus.drain_start = 0;
    chk("first_line_valid", 512'(bus.cl_valid), 512'(1));
    chk("busy_drain", 512'(bus.busy), 512'(1));
    drain_loop(1'b0, 3);

    // even drain of 4 entries with backpressure and a spurious restart
    fill_mem(6);
    push_lines(4);
    bus.drain_cnt = 8'd4; bus.drain_start = 1; bus.cl_ready = 0;
    cyc();
    bus.drain_start = 0;
    drain_loop(1'b1, 2);

    // zero-count drain: no line, drain_done one cycle after start
    bus.drain_cnt = 8'd0; bus.drain_start = 1; bus.cl_ready = 1;
    cyc();
    bus.drain_start = 0;
    chk("zero_cl_valid", 512'(bus.cl_valid), 512'(0));
    chk("zero_done", 512'(bus.drain_done), 512'(1));
    cyc();
    chk("zero_done_clear", 512'(bus.drain_done), 512'(0));
    chk("zero_busy_clear", 512'(bus.busy), 512'(0));

    // reset during the 2nd line of a 6-entry drain
    fill_mem(6);
    bus.drain_cnt = 8'd6; bus.drain_start = 1; bus.cl_ready = 1;
    cyc();
    bus.drain_start = 0;
    chk("rst_test_line1", bus.cl_data, {mem_m[1], mem_m[0]});
    cyc();
    chk("rst_test_line2", bus.cl_data, {mem_m[3], mem_m[2]});
    rst = 1;
    cyc();
    rst = 0;
    chk("midrst_cl_valid", 512'(bus.cl_valid), 512'(0));
    chk("midrst_cl_data", bus.cl_data, 512'(0));
    chk("midrst_cl_last", 512'(bus.cl_last), 512'(0));
    chk("midrst_busy", 512'(bus.busy), 512'(0));
    chk("midrst_rd_valid", 512'(bus.rd_valid), 512'(0));
    chk("midrst_rd_data", 512'(bus.rd_data), 512'(0));
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("after_rst_valid", 512'(bus.cl_valid), 512'(0));
      chk("after_rst_done", 512'(bus.drain_done), 512'(0));
    end

    // arrays keep contents across reset
    bus.rd_en = 1; bus.rd_addr = 7'd9;
    sb_rd.push_back(curr_m[9]);
    cyc();
    bus.rd_en = 0;
    chk("array_survives_rst", 512'(bus.rd_data), 512'(sb_rd.pop_front()));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/smem_store_unit.md
SMEM_STORE_UNIT -- requirements
Module: smem_store_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 128: entries per array (7-bit address).
REQ-002 SHALL have parameter CL, default 512: output cache-line width in bits.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port stall, input, 1: pipeline stall; freezes the read-port outputs.
REQ-006 SHALL have port store_valid_curr, input, 1: current-interval write enable.
REQ-007 SHALL have ports curr_x_0/curr_x_1/curr_x_2/curr_x_info, input, 64 each: current-interval write data.
REQ-008 SHALL have port curr_x_addr, input, 7: current-interval write address.
REQ-009 SHALL have ports store_valid_mem, mem_x_0/1/2/info (64 each) and mem_x_addr (7), input: match-memory write enable, data and address.
REQ-010 SHALL have ports rd_en (input, 1) and rd_addr (input, 7): current-array read request.
REQ-011 SHALL have ports rd_valid (output, 1) and rd_data (output, 256): read response.
REQ-012 SHALL have ports drain_start (input, 1) and drain_cnt (input, 8): start mem-array drain of drain_cnt entries (0..128).
REQ-013 SHALL have ports cl_valid (output, 1), cl_ready (input, 1), cl_data (output, CL) and cl_last (output, 1): drain line stream.
REQ-014 SHALL have ports busy (output, 1) and drain_done (output, 1): drain status.

Function
REQ-015 Entry packing SHALL be {info, x2, x1, x0}, with x0 in bits [63:0].
REQ-016 A store_valid_curr write SHALL update curr[curr_x_addr] at the clock edge; store_valid_mem SHALL update mem[mem_x_addr]. Both writes MAY occur in the same cycle.
REQ-017 Writes SHALL be unaffected by stall and by drain state.
REQ-018 rd_en=1 with stall=0 SHALL produce rd_data=curr[rd_addr] with rd_valid=1 one cycle later (latency 1).
REQ-019 rd_en=0 with stall=0 SHALL drive rd_valid=0 next cycle and hold rd_data.
REQ-020 While stall=1, rd_valid and rd_data SHALL hold their values and rd_en SHALL be ignored.
REQ-021 A read to the address being written in the same cycle SHALL return the new write data (write-first bypass).
REQ-022 The drain FSM SHALL have states IDLE, DRAIN and DONE; busy=1 outside IDLE.
REQ-023 IDLE->DRAIN SHALL occur on drain_start with drain_cnt>0, latching cnt and setting index 0.
REQ-024 IDLE->DONE SHALL occur on drain_start with drain_cnt=0; no line is emitted.
REQ-025 drain_start outside IDLE SHALL be ignored.
REQ-026 In DRAIN, each line SHALL carry mem[index] in cl_data[255:0] and mem[index+1] in cl_data[511:256].
REQ-027 For odd cnt, the upper half of the final line SHALL be zero.
REQ-028 cl_valid and cl_data SHALL stay stable until cl_ready=1.
REQ-029 On accept (cl_valid & cl_ready), index SHALL advance by 2 and the next line SHALL present on the following cycle; back-to-back lines are allowed.
REQ-030 cl_last=1 SHALL accompany exactly the final line, which is line ceil(cnt/2).
REQ-031 Acceptance of the cl_last line SHALL move the FSM to DONE, with cl_valid=0 the next cycle.
REQ-032 DONE SHALL assert drain_done for exactly one cycle, then return to IDLE.
REQ-033 A line SHALL reflect mem contents at the cycle it is first presented; later writes to those addresses SHALL NOT alter a pending line.

Reset
REQ-034 With rst=1 at an edge: rd_valid=0, rd_data=0, cl_valid=0, cl_data=0, cl_last=0, busy=0, drain_done=0, FSM=IDLE, index=0.
REQ-035 Reset SHALL take priority over stall, writes and handshakes; reset mid-drain SHALL abort with no further lines and no drain_done.
REQ-036 Array contents SHALL NOT be reset.

Structure
REQ-037 A shared package SHALL hold DEPTH, CL, the entry width 256 and the FSM state encoding.
REQ-038 One sub-module, smem_entry_ram (1 write port, 1 read port, 256-bit entries), SHALL be instantiated twice, once for curr and once for mem.

Verification
REQ-039 Write curr[5]={4,3,2,1}, then rd_en with rd_addr=5 -> next cycle rd_valid=1, rd_data={4,3,2,1}.
REQ-040 Same-cycle write curr[9]=A with rd_en, rd_addr=9 -> rd_data=A; then stall=1 for 3 cycles with rd_en=1 -> outputs held.
REQ-041 Fill mem[0..4], drain_cnt=5, cl_ready=1 -> 3 lines; line 3 upper half 0 with cl_last=1; drain_done pulses 1 cycle.
REQ-042 drain_cnt=4, cl_ready toggling 0/1 -> cl_data stable while stalled; 2 lines total; second drain_start mid-drain ignored.
REQ-043 drain_cnt=0 -> no cl_valid; drain_done one cycle after start.
REQ-044 rst=1 during the 2nd line of a 6-entry drain -> all outputs 0 next cycle, busy=0, no drain_done.
